// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI/DVI transmit path.
//   mode_t    : per-pixel period code presented to the TMDS channel encoders
//   period_t  : internal per-pixel period classification of the raster
//   CTL_*     : {CTL3..CTL0} codes driven alongside the control period
//   *_LEN     : data-island-free video preamble and leading guard band lengths
package hdmi_pkg;

    typedef enum logic [1:0] {
        MODE_CONTROL     = 2'd0,
        MODE_VIDEO       = 2'd1,
        MODE_VIDEO_GUARD = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        PERIOD_CONTROL,
        PERIOD_PREAMBLE,
        PERIOD_GUARD,
        PERIOD_VIDEO
    } period_t;

    localparam logic [3:0] CTL_VIDEO_PREAMBLE = 4'b0001;
    localparam logic [3:0] CTL_IDLE           = 4'b0000;

    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;

    // A preamble is still a control period on the wire; only CTL differs.
    function automatic mode_t period_mode(input period_t p);
        case (p)
            PERIOD_VIDEO: return MODE_VIDEO;
            PERIOD_GUARD: return MODE_VIDEO_GUARD;
            default:      return MODE_CONTROL;
        endcase
    endfunction

    function automatic logic [3:0] period_ctl(input period_t p);
        return (p == PERIOD_PREAMBLE) ? CTL_VIDEO_PREAMBLE : CTL_IDLE;
    endfunction

endpackage

// File: rtl/hdmi_raster_counter.sv
// Wrapping pixel/line counter pair for the raster timing generator.
//   CLK_PIXEL  in   pixel clock, rising edge
//   RESET      in   asynchronous, active-high; loads (0, INIT_Y)
//   cx, cy     out  current position (registered)
//   next_x/y   out  position the counters will hold after the next edge
module hdmi_raster_counter #(
    parameter int BIT_WIDTH    = 10,
    parameter int BIT_HEIGHT   = 10,
    parameter int FRAME_WIDTH  = 800,
    parameter int FRAME_HEIGHT = 525,
    parameter int INIT_Y       = 480
) (
    input  logic                  CLK_PIXEL,
    input  logic                  RESET,
    output logic [BIT_WIDTH-1:0]  cx,
    output logic [BIT_HEIGHT-1:0] cy,
    output logic [BIT_WIDTH-1:0]  next_x,
    output logic [BIT_HEIGHT-1:0] next_y
);

    localparam logic [BIT_WIDTH-1:0]  X_LAST = BIT_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [BIT_WIDTH-1:0]  X_ONE  = BIT_WIDTH'(1);
    localparam logic [BIT_HEIGHT-1:0] Y_LAST = BIT_HEIGHT'(FRAME_HEIGHT - 1);
    localparam logic [BIT_HEIGHT-1:0] Y_ONE  = BIT_HEIGHT'(1);
    localparam logic [BIT_HEIGHT-1:0] Y_INIT = BIT_HEIGHT'(INIT_Y);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path leaves it unassigned (no latch).
        next_x = cx + X_ONE;
        next_y = cy;
        if (cx == X_LAST) begin
            next_x = '0;
            next_y = (cy == Y_LAST) ? '0 : cy + Y_ONE;
        end
    end

    always_ff @(posedge CLK_PIXEL or posedge RESET) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (RESET) begin
            cx <= '0;
            cy <= Y_INIT;
        end else begin
            cx <= next_x;
            cy <= next_y;
        end
    end

endmodule

// File: rtl/hdmi_timing_gen.sv
// Parametrised raster timing generator for the HDMI/DVI transmit path.
//   CLK_PIXEL    in   pixel clock, all state on rising edge
//   RESET        in   asynchronous, active-high
//   cx, cy       out  current pixel column / line
//   hsync, vsync out  syncs, polarity set by SYNC_POL
//   draw_area    out  1 inside the active picture
//   mode         out  0 control, 1 active video, 2 video guard band
//   ctl          out  {CTL3..CTL0}; preamble code ahead of each active line
//   line_start   out  1 when cx == 0
//   frame_start  out  1 when cx == 0 and cy == 0
// Every output is a register decoded from the counter's next position, so all
// outputs describe the same (cx, cy) in the same cycle.
module hdmi_timing_gen
    import hdmi_pkg::*;
#(
    parameter int BIT_WIDTH     = 10,
    parameter int BIT_HEIGHT    = 10,
    parameter int FRAME_WIDTH   = 800,
    parameter int FRAME_HEIGHT  = 525,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int HSYNC_START   = 656,
    parameter int HSYNC_END     = 752,
    parameter int VSYNC_START   = 490,
    parameter int VSYNC_END     = 492,
    parameter int SYNC_POL      = 1,
    parameter int DVI_OUTPUT    = 0
) (
    input  logic                  CLK_PIXEL,
    input  logic                  RESET,
    output logic [BIT_WIDTH-1:0]  cx,
    output logic [BIT_HEIGHT-1:0] cy,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  draw_area,
    output logic [1:0]            mode,
    output logic [3:0]            ctl,
    output logic                  line_start,
    output logic                  frame_start
);

    localparam logic SYNC_ON        = (SYNC_POL != 0);
    localparam logic DVI            = (DVI_OUTPUT != 0);
    localparam int   GUARD_FIRST    = FRAME_WIDTH - GUARD_LEN;
    localparam int   PREAMBLE_FIRST = GUARD_FIRST - PREAMBLE_LEN;

    if (FRAME_WIDTH - SCREEN_WIDTH < PREAMBLE_LEN + GUARD_LEN) begin : g_err_hblank
        $error("hdmi_timing_gen: horizontal blanking too short for preamble and guard band");
    end
    if (!(SCREEN_WIDTH <= HSYNC_START && HSYNC_START < HSYNC_END && HSYNC_END <= FRAME_WIDTH)) begin : g_err_hsync
        $error("hdmi_timing_gen: hsync must lie inside horizontal blanking");
    end
    if (!(SCREEN_HEIGHT < VSYNC_START && VSYNC_START < VSYNC_END && VSYNC_END <= FRAME_HEIGHT)) begin : g_err_vsync
        $error("hdmi_timing_gen: vsync must lie inside vertical blanking");
    end
    if (FRAME_WIDTH > (1 << BIT_WIDTH) || FRAME_HEIGHT > (1 << BIT_HEIGHT)) begin : g_err_width
        $error("hdmi_timing_gen: counter widths too small for frame size");
    end

    logic [BIT_WIDTH-1:0]  next_x;
    logic [BIT_HEIGHT-1:0] next_y;
    int                    nx;
    int                    ny;
    int                    ny_after;
    logic                  draw_d;
    logic                  hsync_d;
    logic                  vsync_d;
    logic                  next_line_active;
    period_t               period_d;

    hdmi_raster_counter #(
        .BIT_WIDTH    (BIT_WIDTH),
        .BIT_HEIGHT   (BIT_HEIGHT),
        .FRAME_WIDTH  (FRAME_WIDTH),
        .FRAME_HEIGHT (FRAME_HEIGHT),
        .INIT_Y       (SCREEN_HEIGHT)
    ) u_counter (
        .CLK_PIXEL (CLK_PIXEL),
        .RESET     (RESET),
        .cx        (cx),
        .cy        (cy),
        .next_x    (next_x),
        .next_y    (next_y)
    );

    assign nx       = int'(next_x);
    assign ny       = int'(next_y);
    // Line that follows the one being entered; preamble is sent only ahead of active lines.
    assign ny_after = (ny == FRAME_HEIGHT - 1) ? 0 : ny + 1;

    assign next_line_active = (ny_after < SCREEN_HEIGHT);
    assign draw_d  = (nx < SCREEN_WIDTH) && (ny < SCREEN_HEIGHT);
    assign hsync_d = ((nx >= HSYNC_START) && (nx < HSYNC_END)) ? SYNC_ON : ~SYNC_ON;
    assign vsync_d = ((ny >= VSYNC_START) && (ny < VSYNC_END)) ? SYNC_ON : ~SYNC_ON;

    // Period classification of the pixel about to be entered.
    always_comb begin
        period_d = PERIOD_CONTROL;
        if (draw_d) begin
            period_d = PERIOD_VIDEO;
        end else if (!DVI && next_line_active) begin
            if (nx >= GUARD_FIRST) begin
                period_d = PERIOD_GUARD;
            end else if (nx >= PREAMBLE_FIRST) begin
                period_d = PERIOD_PREAMBLE;
            end
        end
    end

    always_ff @(posedge CLK_PIXEL or posedge RESET) begin
        if (RESET) begin
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            draw_area   <= 1'b0;
            mode        <= MODE_CONTROL;
            ctl         <= CTL_IDLE;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            draw_area   <= draw_d;
            mode        <= period_mode(period_d);
            ctl         <= period_ctl(period_d);
            line_start  <= (nx == 0);
            frame_start <= (nx == 0) && (ny == 0);
        end
    end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Self-checking bench for hdmi_timing_gen.
// Four instances share clock and reset: default 640x480 mode, the same mode
// with active-low syncs, and a small 48x20 mode with and without DVI_OUTPUT.
// Expected values are queued against the cycle count since reset release; a
// monitor compares them on falling edges as the raster reaches each position.
module tb_hdmi_timing_gen;

    typedef enum int {
        SIG_D_CX, SIG_D_CY, SIG_D_MODE, SIG_D_CTL, SIG_D_DRAW, SIG_D_LS,
        SIG_D_FS, SIG_D_HS, SIG_D_VS, SIG_N_HS, SIG_N_VS, SIG_S_CY,
        SIG_S_MODE, SIG_S_CTL, SIG_S_FS
    } sig_e;

    typedef struct {
        int    cyc;
        sig_e  sig;
        int    exp;
        string name;
    } exp_t;

    logic clk   = 1'b0;
    logic RESET = 1'b0;
    always #5 clk = ~clk;

    int   cyc_cnt;
    logic mon_en = 1'b0;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    int dvi_draw = 0, dvi_video = 0, dvi_guard = 0, dvi_ctl = 0;
    int sm_ctl = 0, sm_guard = 0, sm_fs_cnt = 0;
    int d_fs_cnt = 0, d_fs_first = -1;

    logic [9:0] d_cx, d_cy, n_cx, n_cy;
    logic       d_hs, d_vs, d_draw, d_ls, d_fs;
    logic       n_hs, n_vs, n_draw, n_ls, n_fs;
    logic [1:0] d_mode, n_mode, s_mode, v_mode;
    logic [3:0] d_ctl, n_ctl, s_ctl, v_ctl;
    logic [5:0] s_cx, v_cx;
    logic [4:0] s_cy, v_cy;
    logic       s_hs, s_vs, s_draw, s_ls, s_fs;
    logic       v_hs, v_vs, v_draw, v_ls, v_fs;

    hdmi_timing_gen u_def (
        .CLK_PIXEL (clk), .RESET (RESET), .cx (d_cx), .cy (d_cy),
        .hsync (d_hs), .vsync (d_vs), .draw_area (d_draw), .mode (d_mode),
        .ctl (d_ctl), .line_start (d_ls), .frame_start (d_fs)
    );

    hdmi_timing_gen #(.SYNC_POL (0)) u_neg (
        .CLK_PIXEL (clk), .RESET (RESET), .cx (n_cx), .cy (n_cy),
        .hsync (n_hs), .vsync (n_vs), .draw_area (n_draw), .mode (n_mode),
        .ctl (n_ctl), .line_start (n_ls), .frame_start (n_fs)
    );

    hdmi_timing_gen #(
        .BIT_WIDTH (6), .BIT_HEIGHT (5), .FRAME_WIDTH (48), .FRAME_HEIGHT (20),
        .SCREEN_WIDTH (32), .SCREEN_HEIGHT (12), .HSYNC_START (36), .HSYNC_END (40),
        .VSYNC_START (14), .VSYNC_END (16)
    ) u_sm (
        .CLK_PIXEL (clk), .RESET (RESET), .cx (s_cx), .cy (s_cy),
        .hsync (s_hs), .vsync (s_vs), .draw_area (s_draw), .mode (s_mode),
        .ctl (s_ctl), .line_start (s_ls), .frame_start (s_fs)
    );

    hdmi_timing_gen #(
        .BIT_WIDTH (6), .BIT_HEIGHT (5), .FRAME_WIDTH (48), .FRAME_HEIGHT (20),
        .SCREEN_WIDTH (32), .SCREEN_HEIGHT (12), .HSYNC_START (36), .HSYNC_END (40),
        .VSYNC_START (14), .VSYNC_END (16), .DVI_OUTPUT (1)
    ) u_dvi (
        .CLK_PIXEL (clk), .RESET (RESET), .cx (v_cx), .cy (v_cy),
        .hsync (v_hs), .vsync (v_vs), .draw_area (v_draw), .mode (v_mode),
        .ctl (v_ctl), .line_start (v_ls), .frame_start (v_fs)
    );

    // Rising edges since reset release; equals pixels advanced from (0, SCREEN_HEIGHT).
    always @(posedge clk or posedge RESET) begin
        if (RESET) cyc_cnt <= 0;
        else       cyc_cnt <= cyc_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic want(input int cyc, input sig_e s, input int v, input string nm);
        exp_t e;
        e.cyc  = cyc;
        e.sig  = s;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    function automatic int actual(input sig_e s);
        case (s)
            SIG_D_CX:   return int'(d_cx);
            SIG_D_CY:   return int'(d_cy);
            SIG_D_MODE: return int'(d_mode);
            SIG_D_CTL:  return int'(d_ctl);
            SIG_D_DRAW: return int'(d_draw);
            SIG_D_LS:   return int'(d_ls);
            SIG_D_FS:   return int'(d_fs);
            SIG_D_HS:   return int'(d_hs);
            SIG_D_VS:   return int'(d_vs);
            SIG_N_HS:   return int'(n_hs);
            SIG_N_VS:   return int'(n_vs);
            SIG_S_CY:   return int'(s_cy);
            SIG_S_MODE: return int'(s_mode);
            SIG_S_CTL:  return int'(s_ctl);
            SIG_S_FS:   return int'(s_fs);
            default:    return -1;
        endcase
    endfunction

    // Monitor: compare every queued expectation due at this cycle, keep window counts.
    always @(negedge clk) begin
        if (mon_en && !RESET) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc_cnt) begin
                    check($sformatf("%s@%0d", sb[i].name, sb[i].cyc), actual(sb[i].sig), sb[i].exp);
                    sb.delete(i);
                end
            end
            if (cyc_cnt >= 384 && cyc_cnt <= 1343) begin
                dvi_draw  += int'(v_draw);
                dvi_video += (v_mode == 2'd1) ? 1 : 0;
                dvi_guard += (v_mode == 2'd2) ? 1 : 0;
                dvi_ctl   += (v_ctl != 4'd0) ? 1 : 0;
                sm_ctl    += (s_ctl == 4'b0001) ? 1 : 0;
                sm_guard  += (s_mode == 2'd2) ? 1 : 0;
            end
            if (cyc_cnt <= 2400 && s_fs) sm_fs_cnt++;
            if (d_fs) begin
                d_fs_cnt++;
                if (d_fs_first < 0) d_fs_first = cyc_cnt;
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_cx"},    int'(d_cx), 0);
        check({tag, "_cy"},    int'(d_cy), 480);
        check({tag, "_hs"},    int'(d_hs), 0);
        check({tag, "_vs"},    int'(d_vs), 0);
        check({tag, "_draw"},  int'(d_draw), 0);
        check({tag, "_mode"},  int'(d_mode), 0);
        check({tag, "_ctl"},   int'(d_ctl), 0);
        check({tag, "_ls"},    int'(d_ls), 0);
        check({tag, "_fs"},    int'(d_fs), 0);
        check({tag, "_neg_hs"}, int'(n_hs), 1);
        check({tag, "_neg_vs"}, int'(n_vs), 1);
        check({tag, "_sm_cy"}, int'(s_cy), 12);
    endtask

    initial begin
        bit found;

        // Default mode, first edge and the bottom-of-frame preamble (line 524 at cycle 35200+cx).
        want(1, SIG_D_CX, 1, "first_cx");
        want(1, SIG_D_CY, 480, "first_cy");
        for (int x = 789; x <= 799; x++) begin
            want(35200 + x, SIG_D_CY, 524, "l524_cy");
            want(35200 + x, SIG_D_MODE, (x >= 798) ? 2 : 0, "l524_mode");
            want(35200 + x, SIG_D_CTL, (x >= 790 && x <= 797) ? 1 : 0, "l524_ctl");
        end
        want(35999, SIG_D_FS, 0, "fs_before");
        want(35999, SIG_D_LS, 0, "ls_before");
        want(36000, SIG_D_CX, 0, "wrap_cx");
        want(36000, SIG_D_CY, 0, "wrap_cy");
        want(36000, SIG_D_MODE, 1, "wrap_mode");
        want(36000, SIG_D_DRAW, 1, "wrap_draw");
        want(36000, SIG_D_CTL, 0, "wrap_ctl");
        want(36000, SIG_D_FS, 1, "wrap_fs");
        want(36000, SIG_D_LS, 1, "wrap_ls");
        want(36001, SIG_D_LS, 0, "ls_after");
        want(36001, SIG_D_FS, 0, "fs_after");
        want(36639, SIG_D_DRAW, 1, "draw_last_col");
        want(36639, SIG_D_MODE, 1, "mode_last_col");
        want(36640, SIG_D_DRAW, 0, "draw_hblank");
        want(36640, SIG_D_MODE, 0, "mode_hblank");
        want(36789, SIG_D_CTL, 0, "l0_pre_ctl");
        want(36790, SIG_D_CTL, 1, "l0_first_pre");
        want(36797, SIG_D_CTL, 1, "l0_last_pre");
        want(36798, SIG_D_MODE, 2, "l0_guard");
        want(36798, SIG_D_CTL, 0, "l0_guard_ctl");
        want(36800, SIG_D_CY, 1, "l1_cy");
        want(36800, SIG_D_MODE, 1, "l1_mode");

        // Sync windows on line 480 and across lines 489..492.
        want(655, SIG_N_HS, 1, "neg_hs_655");
        want(656, SIG_N_HS, 0, "neg_hs_656");
        want(751, SIG_N_HS, 0, "neg_hs_751");
        want(752, SIG_N_HS, 1, "neg_hs_752");
        want(656, SIG_D_HS, 1, "pos_hs_656");
        want(752, SIG_D_HS, 0, "pos_hs_752");
        want(7999, SIG_N_VS, 1, "neg_vs_489");
        want(8000, SIG_N_VS, 0, "neg_vs_490");
        want(9599, SIG_N_VS, 0, "neg_vs_491");
        want(9600, SIG_N_VS, 1, "neg_vs_492");
        want(8000, SIG_D_VS, 1, "pos_vs_490");
        want(9600, SIG_D_VS, 0, "pos_vs_492");

        // Small mode: blanking line 12 and last active line 11 get no preamble;
        // line 19 (before frame) and line 10 (before last active) do.
        for (int x = 38; x <= 47; x++) begin
            want(x, SIG_S_CTL, 0, "sm_l12_ctl");
            want(x, SIG_S_MODE, 0, "sm_l12_mode");
            want(912 + x, SIG_S_CTL, 0, "sm_l11_ctl");
            want(912 + x, SIG_S_MODE, 0, "sm_l11_mode");
        end
        for (int x = 37; x <= 47; x++) begin
            want(336 + x, SIG_S_CTL, (x >= 38 && x <= 45) ? 1 : 0, "sm_l19_ctl");
            want(336 + x, SIG_S_MODE, (x >= 46) ? 2 : 0, "sm_l19_mode");
            want(864 + x, SIG_S_CTL, (x >= 38 && x <= 45) ? 1 : 0, "sm_l10_ctl");
            want(864 + x, SIG_S_MODE, (x >= 46) ? 2 : 0, "sm_l10_mode");
        end
        want(384, SIG_S_CY, 0, "sm_wrap_cy");
        want(384, SIG_S_MODE, 1, "sm_wrap_mode");
        want(384, SIG_S_FS, 1, "sm_fs_1");
        want(1343, SIG_S_FS, 0, "sm_fs_gap");
        want(1344, SIG_S_FS, 1, "sm_fs_2");
        want(2304, SIG_S_FS, 1, "sm_fs_3");

        // Reset state, held across edges, then just after release.
        #1 RESET = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("rst_hold");
        #2 RESET = 1'b0;
        #1 check_reset_values("rst_release");
        mon_en = 1'b1;

        // Run to the middle of the preamble ahead of line 11: (795, 10).
        found = 1'b0;
        for (int i = 0; i < 50000 && !found; i++) begin
            @(negedge clk);
            if (cyc_cnt == 44795) found = 1'b1;
        end
        check("reach_mid_preamble", int'(found), 1);
        check("mid_cx", int'(d_cx), 795);
        check("mid_cy", int'(d_cy), 10);
        check("mid_ctl", int'(d_ctl), 1);

        check("def_fs_count", d_fs_cnt, 1);
        check("def_fs_first", d_fs_first, 36000);
        check("sm_fs_count", sm_fs_cnt, 3);
        check("dvi_draw_count", dvi_draw, 384);
        check("dvi_video_count", dvi_video, 384);
        check("dvi_guard_count", dvi_guard, 0);
        check("dvi_ctl_count", dvi_ctl, 0);
        check("sm_preamble_count", sm_ctl, 96);
        check("sm_guard_count", sm_guard, 24);
        check("scoreboard_drained", sb.size(), 0);
        mon_en = 1'b0;

        // Asynchronous reset mid-preamble: takes effect before the next rising edge.
        #2 RESET = 1'b1;
        #1 check_reset_values("rst_async");
        repeat (3) @(negedge clk);
        #2 RESET = 1'b0;
        #1 check_reset_values("rst_rerelease");
        @(negedge clk);
        check("post_cx", int'(d_cx), 1);
        check("post_cy", int'(d_cy), 480);
        check("post_ctl", int'(d_ctl), 0);
        check("post_mode", int'(d_mode), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
